// File: rtl/ddr3_rd_arbiter.sv
// Two-requester AXI4 read arbiter in front of the DDR3 controller.
// Round-robin grant with one burst in flight. R beats are routed to the
// current owner. No request is accepted until calibration is done. A sticky
// flag records any disagreement between the rlast position and arlen.
//
// Handshakes: a transfer on any AR or R channel happens on the rising clk
// edge where both valid and ready are 1. Once a valid is raised, the sender
// holds it and its payload until that edge. mN_arready is combinational and
// is high only in IDLE, and only for the requester that wins that cycle.
module ddr3_rd_arbiter #(
    parameter int ID_W   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              phy_init_done,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [7:0]        m0_arlen,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [7:0]        m1_arlen,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [ID_W-1:0]   s_axi_arid,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic [7:0]        s_axi_arlen,
    output logic [2:0]        s_axi_arsize,
    output logic [1:0]        s_axi_arburst,
    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    input  logic [ID_W-1:0]   s_axi_rid,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp,
    input  logic              s_axi_rlast,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready,
    output logic              err_beat,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_W / 8));

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [ID_W-1:0]   arid_q, arid_d;
    logic              arvalid_q, arvalid_d;

    logic              can_grant;
    logic              pick;
    logic              ar_fire;
    logic              in_data;
    logic              r_fire;

    // Only one burst is ever in flight, so the returned ID carries no information.
    logic              unused_rid;
    assign unused_rid = ^s_axi_rid;

    // Request side: pick this cycle's winner and raise its one-cycle arready.
    always_comb begin
        can_grant = aresetn && (state_q == IDLE) && phy_init_done;
        if (m0_arvalid && m1_arvalid) begin
            pick = ~last_grant_q;
        end else begin
            pick = m1_arvalid;
        end
        m0_arready = can_grant && m0_arvalid && !pick;
        m1_arready = can_grant && m1_arvalid && pick;
        ar_fire    = m0_arready || m1_arready;
    end

    // Read data side: route beats to the owner; the other requester sees nothing.
    always_comb begin
        in_data      = (state_q == DATA);
        s_axi_rready = in_data && (owner_q ? m1_rready : m0_rready);
        r_fire       = s_axi_rvalid && s_axi_rready;
        m0_rvalid    = in_data && !owner_q && s_axi_rvalid;
        m0_rdata     = (in_data && !owner_q) ? s_axi_rdata : '0;
        m0_rresp     = (in_data && !owner_q) ? s_axi_rresp : 2'b00;
        m0_rlast     = in_data && !owner_q && s_axi_rlast;
        m1_rvalid    = in_data && owner_q && s_axi_rvalid;
        m1_rdata     = (in_data && owner_q) ? s_axi_rdata : '0;
        m1_rresp     = (in_data && owner_q) ? s_axi_rresp : 2'b00;
        m1_rlast     = in_data && owner_q && s_axi_rlast;
    end

    // Next-state logic for the IDLE -> ADDR -> DATA -> IDLE walk.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arid_d       = arid_q;
        arvalid_d    = arvalid_q;
        case (state_q)
            IDLE: begin
                if (ar_fire) begin
                    owner_d   = pick;
                    araddr_d  = pick ? m1_araddr : m0_araddr;
                    arlen_d   = pick ? m1_arlen : m0_arlen;
                    arid_d    = ID_W'(pick);
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (s_axi_arready) begin
                    arvalid_d  = 1'b0;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (r_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (s_axi_rlast) begin
                        // Early rlast still ends the burst; it is only flagged.
                        if (beat_cnt_q != arlen_q) begin
                            err_d = 1'b1;
                        end
                        last_grant_d = owner_q;
                        state_d      = IDLE;
                    end else if (beat_cnt_q == arlen_q) begin
                        // Missing rlast: flag it and keep routing until rlast arrives.
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered AR outputs; m0 wins the first contested grant after reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            beat_cnt_q   <= 8'd0;
            err_q        <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arid_q       <= '0;
            arvalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arid_q       <= arid_d;
            arvalid_q    <= arvalid_d;
        end
    end

    assign s_axi_arid    = arid_q;
    assign s_axi_araddr  = araddr_q;
    assign s_axi_arlen   = arlen_q;
    assign s_axi_arsize  = ARSIZE;
    assign s_axi_arburst = 2'b01;
    assign s_axi_arvalid = arvalid_q;
    assign err_beat      = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ddr3_rd_arbiter.sv
// Bench for ddr3_rd_arbiter. It acts as both requesters and the DDR3
// controller. A reference model tracks the round-robin owner and the sticky
// beat error. A scoreboard pairs each beat the controller hands over with the
// beat the owning requester receives.
module tb_ddr3_rd_arbiter;

    localparam int ID_W   = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              phy_init_done;
    logic [ADDR_W-1:0] m0_araddr, m1_araddr;
    logic [7:0]        m0_arlen, m1_arlen;
    logic              m0_arvalid, m1_arvalid;
    logic              m0_arready, m1_arready;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        m0_rresp, m1_rresp;
    logic              m0_rlast, m1_rlast;
    logic              m0_rvalid, m1_rvalid;
    logic              m0_rready, m1_rready;
    logic [ID_W-1:0]   s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              err_beat;
    logic [1:0]        dbg_state;

    ddr3_rd_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .aresetn(aresetn), .phy_init_done(phy_init_done),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .err_beat(err_beat), .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected beats, packed as {requester, rresp, rlast, rdata}.
    logic [35:0] exp_q[$];

    // Reference model: owner of the most recent completed burst, and the sticky error.
    int model_last;
    bit model_err;

    function automatic int model_pick(input bit v0, input bit v1);
        if (v0 && v1) return (model_last == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    function automatic void model_done(input int owner, input int nbeats, input int len);
        model_last = owner;
        if (nbeats != len + 1) model_err = 1'b1;
    endfunction

    // Observations from the last run_burst call.
    int                g_grant;
    bit                g_timeout;
    bit                g_arv_lat;
    bit                g_stable;
    int                g_rready_bad;
    logic [ID_W-1:0]   g_id;
    logic [ADDR_W-1:0] g_addr;
    logic [7:0]        g_len;

    // Scoreboard: a requester-side handshake must match the next expected beat.
    logic        sb_v, sb_rd;
    logic [35:0] sb_obs, sb_exp;
    always begin
        @(negedge clk);
        #2;
        if (aresetn === 1'b1) begin
            for (int r = 0; r < 2; r++) begin
                sb_v   = (r == 1) ? m1_rvalid : m0_rvalid;
                sb_rd  = (r == 1) ? m1_rready : m0_rready;
                sb_obs = (r == 1) ? {1'b1, m1_rresp, m1_rlast, m1_rdata} : {1'b0, m0_rresp, m0_rlast, m0_rdata};
                if (sb_v === 1'b1 && sb_rd === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_beat req%0d got %h required no beat", r, sb_obs);
                    end else begin
                        sb_exp = exp_q.pop_front();
                        if (sb_obs !== sb_exp) begin
                            errors++;
                            $display("FAIL sb_beat req%0d got %h required %h", r, sb_obs, sb_exp);
                        end
                    end
                end
            end
        end
    end

    // Driver: called at the sample point (negedge + 1). Waits for a grant,
    // accepts the address after a random delay, then returns nbeats beats
    // with rlast on the final one. Ends at the sample point after the burst.
    task automatic run_burst(input int owner, input int nbeats, input bit hold, input bit throttle);
        bit got;
        g_timeout    = 1'b0;
        g_grant      = -1;
        g_stable     = 1'b1;
        g_rready_bad = 0;
        g_arv_lat    = 1'b0;
        got          = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (m0_arready === 1'b1 || m1_arready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!got) begin
            g_timeout = 1'b1;
            return;
        end
        g_grant = (m1_arready === 1'b1) ? 1 : 0;
        @(negedge clk);
        if (!hold) begin
            if (g_grant == 0) m0_arvalid = 1'b0;
            else m1_arvalid = 1'b0;
        end
        #1;
        g_arv_lat = s_axi_arvalid;
        g_id      = s_axi_arid;
        g_addr    = s_axi_araddr;
        g_len     = s_axi_arlen;
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            #1;
            if (s_axi_arvalid !== 1'b1 || s_axi_araddr !== g_addr || s_axi_arlen !== g_len || s_axi_arid !== g_id)
                g_stable = 1'b0;
        end
        @(negedge clk);
        s_axi_arready = 1'b1;
        #1;
        if (s_axi_arvalid !== 1'b1) g_stable = 1'b0;
        @(negedge clk);
        s_axi_arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axi_rvalid = 1'b0;
                s_axi_rlast  = 1'b0;
                #1;
                @(negedge clk);
            end
            s_axi_rvalid = 1'b1;
            s_axi_rdata  = $urandom;
            s_axi_rresp  = 2'($urandom_range(0, 3));
            s_axi_rlast  = (i == nbeats - 1);
            s_axi_rid    = ID_W'(owner);
            if (throttle) begin
                if (owner == 1) m1_rready = ~m1_rready;
                else m0_rready = ~m0_rready;
            end
            #1;
            got = 1'b0;
            for (int n = 0; n < 20; n++) begin
                if (s_axi_rready !== ((owner == 1) ? m1_rready : m0_rready)) g_rready_bad++;
                if (s_axi_rready === 1'b1) begin
                    exp_q.push_back({1'(owner), s_axi_rresp, s_axi_rlast, s_axi_rdata});
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
                if (throttle) begin
                    if (owner == 1) m1_rready = ~m1_rready;
                    else m0_rready = ~m0_rready;
                end
                #1;
            end
            if (!got) begin
                g_timeout    = 1'b1;
                s_axi_rvalid = 1'b0;
                s_axi_rlast  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_axi_rvalid = 1'b0;
        s_axi_rlast  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        phy_init_done = 1'b1;
        m0_arvalid = 1'b1;
        m0_araddr = 32'h1000;
        repeat (3) @(negedge clk);
        #1;
        checks++; if ({m0_arready, m0_rdata, m0_rresp, m0_rlast, m0_rvalid, m1_arready, m1_rdata, m1_rresp, m1_rlast, m1_rvalid,
                       s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready, err_beat} !== '0) begin
            errors++; $display("FAIL reset_outputs got arready0=%b arvalid=%b araddr=%h err=%b required all 0", m0_arready, s_axi_arvalid, s_axi_araddr, err_beat); end
        checks++; if (s_axi_arsize !== 3'd2) begin errors++; $display("FAIL reset_arsize got %0d required 2", s_axi_arsize); end
        checks++; if (s_axi_arburst !== 2'b01) begin errors++; $display("FAIL reset_arburst got %0d required 1", s_axi_arburst); end
        @(negedge clk);
        m0_arvalid = 1'b0;
        phy_init_done = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        model_last = 1;
        model_err = 1'b0;
        #1;
    endtask

    task automatic test_init_gate();
        int bad;
        int exp;
        bad = 0;
        @(negedge clk);
        phy_init_done = 1'b0;
        m0_araddr = 32'h0000_2000;
        m0_arlen = 8'd0;
        m0_arvalid = 1'b1;
        #1;
        repeat (20) begin
            if (m0_arready !== 1'b0 || s_axi_arvalid !== 1'b0) bad++;
            @(negedge clk);
            #1;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL init_gate_blocked got %0d bad cycles required 0", bad); end
        @(negedge clk);
        phy_init_done = 1'b1;
        #1;
        checks++; if (m0_arready !== 1'b1) begin errors++; $display("FAIL init_gate_release got %b required 1", m0_arready); end
        exp = model_pick(1'b1, 1'b0);
        run_burst(exp, 1, 1'b0, 1'b0);
        checks++; if (g_timeout !== 1'b0 || g_grant !== exp) begin errors++; $display("FAIL init_gate_grant got %0d timeout %b required %0d", g_grant, g_timeout, exp); end
        model_done(exp, 1, 0);
    endtask

    task automatic test_single_m0();
        @(negedge clk);
        m0_araddr = 32'hA400_0100;
        m0_arlen = 8'd3;
        m0_arvalid = 1'b1;
        #1;
        run_burst(0, 4, 1'b0, 1'b0);
        model_done(0, 4, 3);
        checks++; if (g_timeout !== 1'b0 || g_grant !== 0) begin errors++; $display("FAIL m0_grant got %0d timeout %b required 0", g_grant, g_timeout); end
        checks++; if (g_arv_lat !== 1'b1) begin errors++; $display("FAIL m0_arvalid_latency got %b required 1", g_arv_lat); end
        checks++; if (g_addr !== 32'hA400_0100) begin errors++; $display("FAIL m0_araddr got %h required a4000100", g_addr); end
        checks++; if (g_len !== 8'd3) begin errors++; $display("FAIL m0_arlen got %0d required 3", g_len); end
        checks++; if (g_id !== 2'd0) begin errors++; $display("FAIL m0_arid got %0d required 0", g_id); end
        checks++; if (s_axi_arsize !== 3'd2 || s_axi_arburst !== 2'b01) begin errors++; $display("FAIL m0_size_burst got %0d/%0d required 2/1", s_axi_arsize, s_axi_arburst); end
        checks++; if (g_stable !== 1'b1) begin errors++; $display("FAIL m0_ar_stable got %b required 1", g_stable); end
        checks++; if (err_beat !== model_err) begin errors++; $display("FAIL m0_err_beat got %b required %b", err_beat, model_err); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL m0_beats_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_throttle_m1();
        @(negedge clk);
        m1_araddr = 32'h0BAD_0040;
        m1_arlen = 8'd7;
        m1_rready = 1'b1;
        m1_arvalid = 1'b1;
        #1;
        run_burst(1, 8, 1'b0, 1'b1);
        model_done(1, 8, 7);
        m1_rready = 1'b1;
        checks++; if (g_timeout !== 1'b0 || g_grant !== 1) begin errors++; $display("FAIL thr_grant got %0d timeout %b required 1", g_grant, g_timeout); end
        checks++; if (g_id !== 2'd1 || g_len !== 8'd7) begin errors++; $display("FAIL thr_id_len got %0d/%0d required 1/7", g_id, g_len); end
        checks++; if (g_rready_bad !== 0) begin errors++; $display("FAIL thr_rready_follow got %0d bad cycles required 0", g_rready_bad); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL thr_beats_left got %0d required 0", exp_q.size()); end
        @(negedge clk);
        s_axi_rvalid = 1'b1;
        #1;
        checks++; if (s_axi_rready !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL thr_idle_after got rready %b rvalid %b required 0 0", s_axi_rready, m1_rvalid); end
        @(negedge clk);
        s_axi_rvalid = 1'b0;
        #1;
    endtask

    task automatic test_round_robin();
        int exp;
        @(negedge clk);
        m0_araddr = 32'h0000_0A00;
        m1_araddr = 32'h0000_0B00;
        m0_arlen = 8'd0;
        m1_arlen = 8'd0;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            run_burst(exp, 1, 1'b1, 1'b0);
            model_done(exp, 1, 0);
            checks++; if (g_timeout !== 1'b0 || g_grant !== exp) begin errors++; $display("FAIL rr_grant%0d got %0d required %0d", k, g_grant, exp); end
            checks++; if (g_id !== ID_W'(exp)) begin errors++; $display("FAIL rr_arid%0d got %0d required %0d", k, g_id, exp); end
            checks++; if (g_addr !== ((exp == 1) ? m1_araddr : m0_araddr)) begin errors++; $display("FAIL rr_addr%0d got %h", k, g_addr); end
        end
        // Both requesters withdraw before the pending grant completes.
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (s_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rr_withdraw got arvalid %b required 0", s_axi_arvalid); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rr_beats_left got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_early_rlast();
        int exp;
        @(negedge clk);
        m0_araddr = 32'h0000_3000;
        m0_arlen = 8'd3;
        m0_arvalid = 1'b1;
        #1;
        exp = model_pick(1'b1, 1'b0);
        run_burst(exp, 2, 1'b0, 1'b0);
        model_done(exp, 2, 3);
        checks++; if (g_timeout !== 1'b0) begin errors++; $display("FAIL early_done got timeout %b required 0", g_timeout); end
        checks++; if (err_beat !== 1'b1) begin errors++; $display("FAIL early_err got %b required 1", err_beat); end
        @(negedge clk);
        s_axi_rvalid = 1'b1;
        #1;
        checks++; if (s_axi_rready !== 1'b0 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL early_idle got rready %b rvalid %b required 0 0", s_axi_rready, m0_rvalid); end
        @(negedge clk);
        s_axi_rvalid = 1'b0;
        m1_araddr = 32'h0000_4000;
        m1_arlen = 8'd2;
        m1_arvalid = 1'b1;
        #1;
        exp = model_pick(1'b0, 1'b1);
        run_burst(exp, 3, 1'b0, 1'b0);
        model_done(exp, 3, 2);
        checks++; if (g_timeout !== 1'b0 || g_grant !== exp) begin errors++; $display("FAIL early_next_grant got %0d required %0d", g_grant, exp); end
        checks++; if (err_beat !== 1'b1) begin errors++; $display("FAIL early_sticky got %b required 1", err_beat); end
    endtask

    task automatic test_async_reset();
        bit got;
        got = 1'b0;
        @(negedge clk);
        m0_araddr = 32'h0000_5000;
        m0_arlen = 8'd3;
        m0_arvalid = 1'b1;
        #1;
        for (int n = 0; n < 20; n++) begin
            if (m0_arready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ar_grant_wait got timeout required m0_arready"); end
        @(negedge clk);
        m0_arvalid = 1'b0;
        @(negedge clk);
        s_axi_arready = 1'b1;
        @(negedge clk);
        s_axi_arready = 1'b0;
        m0_rready = 1'b0;
        s_axi_rvalid = 1'b1;
        s_axi_rdata = $urandom;
        #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL ar_beat1_routed got %b required 1", m0_rvalid); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if ({m0_arready, m0_rdata, m0_rresp, m0_rlast, m0_rvalid, m1_arready, m1_rdata, m1_rresp, m1_rlast, m1_rvalid,
                       s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready, err_beat} !== '0) begin
            errors++; $display("FAIL ar_outputs_zero got rvalid0=%b araddr=%h err=%b required all 0", m0_rvalid, s_axi_araddr, err_beat); end
        @(negedge clk);
        s_axi_rvalid = 1'b0;
        m0_rready = 1'b1;
        @(negedge clk);
        aresetn = 1'b1;
        model_last = 1;
        model_err = 1'b0;
        exp_q.delete();
        @(negedge clk);
        m0_araddr = 32'h0000_6000;
        m1_araddr = 32'h0000_7000;
        m0_arlen = 8'd1;
        m1_arlen = 8'd0;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        #1;
        checks++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin errors++; $display("FAIL ar_first_contest got %b%b required 10", m0_arready, m1_arready); end
        run_burst(0, 2, 1'b0, 1'b0);
        model_done(0, 2, 1);
        checks++; if (g_grant !== 0 || g_addr !== 32'h0000_6000) begin errors++; $display("FAIL ar_post_m0 got %0d %h required 0 00006000", g_grant, g_addr); end
        run_burst(1, 1, 1'b0, 1'b0);
        model_done(1, 1, 0);
        checks++; if (g_grant !== 1 || g_addr !== 32'h0000_7000) begin errors++; $display("FAIL ar_post_m1 got %0d %h required 1 00007000", g_grant, g_addr); end
        checks++; if (err_beat !== 1'b0) begin errors++; $display("FAIL ar_err_cleared got %b required 0", err_beat); end
    endtask

    task automatic test_random();
        int exp, len, nb;
        for (int it = 0; it < 16; it++) begin
            if (m0_arvalid !== 1'b1 && m1_arvalid !== 1'b1) begin
                int pat;
                @(negedge clk);
                pat = $urandom_range(1, 3);
                if (pat[0]) begin m0_araddr = $urandom; m0_arlen = 8'($urandom_range(0, 5)); m0_arvalid = 1'b1; end
                if (pat[1]) begin m1_araddr = $urandom; m1_arlen = 8'($urandom_range(0, 5)); m1_arvalid = 1'b1; end
                #1;
            end
            exp = model_pick(m0_arvalid, m1_arvalid);
            len = (exp == 1) ? int'(m1_arlen) : int'(m0_arlen);
            nb  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len + 2) : len + 1;
            run_burst(exp, nb, 1'b0, 1'b0);
            model_done(exp, nb, len);
            checks++; if (g_timeout !== 1'b0 || g_grant !== exp) begin errors++; $display("FAIL rnd_grant%0d got %0d timeout %b required %0d", it, g_grant, g_timeout, exp); end
            checks++; if (g_len !== 8'(len) || g_id !== ID_W'(exp)) begin errors++; $display("FAIL rnd_len_id%0d got %0d/%0d required %0d/%0d", it, g_len, g_id, len, exp); end
            checks++; if (err_beat !== model_err) begin errors++; $display("FAIL rnd_err%0d got %b required %b", it, err_beat, model_err); end
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (s_axi_arvalid !== 1'b0) begin errors++; $display("FAIL rnd_drain got arvalid %b required 0", s_axi_arvalid); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_beats_left got %0d required 0", exp_q.size()); end
    endtask

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        phy_init_done = 1'b0;
        m0_araddr = '0; m0_arlen = '0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arlen = '0; m1_arvalid = 1'b0; m1_rready = 1'b1;
        s_axi_arready = 1'b0;
        s_axi_rid = '0; s_axi_rdata = '0; s_axi_rresp = 2'b00; s_axi_rlast = 1'b0; s_axi_rvalid = 1'b0;
        model_last = 1;
        model_err = 1'b0;
        test_reset();
        test_init_gate();
        test_single_m0();
        test_throttle_m1();
        test_round_robin();
        test_early_rlast();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
